// File: rtl/rlrd_pkg.sv
// Shared constants for the RLRD random-number receive path.
package rlrd_pkg;

    localparam int unsigned RNG_WORD_W     = 32;
    localparam int unsigned ACC_CNT_W      = 6;

    localparam int unsigned TAGQ_DEPTH_DEF = 16;
    localparam int unsigned OUT_DEPTH_DEF  = 16;

    // Bit offsets inside the sticky error/status vector.
    localparam int unsigned ERR_TAGQ_OVF_BIT = 0;
    localparam int unsigned ERR_ORPHAN_BIT   = 1;
    localparam int unsigned ERR_W            = 2;

endpackage

// File: rtl/rlrd_sync_fifo.sv
// Generic synchronous FIFO with registered full/empty/count.
// A push is accepted when not full or when a pop is accepted in the same cycle.
module rlrd_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             rd_ok;
    logic             wr_ok;
    logic [CW-1:0]    cnt_nxt;

    assign rd_ok   = pop && !empty;
    assign wr_ok   = push && (!full || rd_ok);
    assign cnt_nxt = count + CW'(wr_ok) - CW'(rd_ok);
    assign dout    = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_ok) begin
                rptr <= rptr + AW'(1);
            end
            count <= cnt_nxt;
            full  <= (cnt_nxt == CW'(DEPTH));
            empty <= (cnt_nxt == '0);
        end
    end

endmodule

// File: rtl/rlrd_rng_collector.sv
// RLRD RNG collector: tags returned bursts, samples configured bit positions and packs 32-bit words.
// Optional von Neumann debiasing stage enabled by RLRD_RNG_VN_DEBIAS_EN.
module rlrd_rng_collector
    import rlrd_pkg::*;
#(
    parameter int unsigned DATA_W     = 512,
    parameter int unsigned IDX_W      = 9,
    parameter int unsigned N_IDX      = 8,
    parameter int unsigned TAGQ_DEPTH = TAGQ_DEPTH_DEF,
    parameter int unsigned OUT_DEPTH  = OUT_DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_issue,
    input  logic                    rd_issue_is_rng,
    input  logic                    rd_data_valid,
    input  logic [DATA_W-1:0]       rd_data,
    input  logic [N_IDX*IDX_W-1:0]  cfg_idx,
    output logic                    rng_valid,
    output logic [RNG_WORD_W-1:0]   rng_data,
    input  logic                    rng_ready,
    output logic                    rng_fifo_full,
    output logic                    err_tagq_ovf,
    output logic                    err_orphan,
    output logic [15:0]             drop_cnt
);

    localparam int unsigned ACC_W = RNG_WORD_W + N_IDX;

    logic                         tq_dout;
    logic                         tq_full;
    logic                         tq_empty;
    logic [$clog2(TAGQ_DEPTH):0]  tq_count;
    logic                         beat_ok;

    rlrd_sync_fifo #(
        .WIDTH (1),
        .DEPTH (TAGQ_DEPTH)
    ) u_tagq (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_issue),
        .din   (rd_issue_is_rng),
        .pop   (rd_data_valid),
        .dout  (tq_dout),
        .full  (tq_full),
        .empty (tq_empty),
        .count (tq_count)
    );

    // A push into an empty queue never serves the same-cycle beat.
    assign beat_ok = rd_data_valid && !tq_empty;

    logic [N_IDX-1:0] sample;
    logic [N_IDX-1:0] s1_bits;
    logic             s1_v;

    always_comb begin
        sample = '0;
        for (int unsigned k = 0; k < N_IDX; k++) begin
            sample[k] = rd_data[cfg_idx[k*IDX_W +: IDX_W]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_bits <= '0;
        end else begin
            s1_v <= beat_ok && tq_dout;
            if (beat_ok && tq_dout) begin
                s1_bits <= sample;
            end
        end
    end

    logic [N_IDX-1:0]     ins_bits;
    logic [ACC_CNT_W-1:0] ins_n;
    logic                 ins_v;

`ifdef RLRD_RNG_VN_DEBIAS_EN
    logic [N_IDX-1:0]     vn_bits;
    logic [ACC_CNT_W-1:0] vn_n;
    logic [N_IDX-1:0]     s2_bits;
    logic [ACC_CNT_W-1:0] s2_n;
    logic                 s2_v;

    // Pair {b[2j+1],b[2j]}: 01 -> 0, 10 -> 1, equal pairs emit nothing; output is packed LSB first.
    always_comb begin
        int unsigned p;
        p       = 0;
        vn_bits = '0;
        for (int unsigned j = 0; j < N_IDX/2; j++) begin
            if (s1_bits[2*j] != s1_bits[2*j+1]) begin
                vn_bits = vn_bits | (N_IDX'(s1_bits[2*j+1]) << p);
                p       = p + 1;
            end
        end
        vn_n = ACC_CNT_W'(p);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v    <= 1'b0;
            s2_bits <= '0;
            s2_n    <= '0;
        end else begin
            s2_v    <= s1_v;
            s2_bits <= vn_bits;
            s2_n    <= vn_n;
        end
    end

    assign ins_bits = s2_bits;
    assign ins_n    = s2_n;
    assign ins_v    = s2_v;
`else
    assign ins_bits = s1_bits;
    assign ins_n    = ACC_CNT_W'(N_IDX);
    assign ins_v    = s1_v;
`endif

    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     merged;
    logic [ACC_CNT_W-1:0] acc_cnt;
    logic [ACC_CNT_W-1:0] total;
    logic                 word_done;

    assign merged    = acc | (ACC_W'(ins_bits) << acc_cnt);
    assign total     = acc_cnt + ins_n;
    assign word_done = ins_v && (total >= ACC_CNT_W'(RNG_WORD_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            acc_cnt <= '0;
        end else if (ins_v) begin
            if (word_done) begin
                acc     <= merged >> RNG_WORD_W;
                acc_cnt <= total - ACC_CNT_W'(RNG_WORD_W);
            end else begin
                acc     <= merged;
                acc_cnt <= total;
            end
        end
    end

    logic                        of_full;
    logic                        of_empty;
    logic [$clog2(OUT_DEPTH):0]  of_count;
    logic                        drop;

    rlrd_sync_fifo #(
        .WIDTH (RNG_WORD_W),
        .DEPTH (OUT_DEPTH)
    ) u_outq (
        .clk   (clk),
        .rst   (rst),
        .push  (word_done),
        .din   (merged[RNG_WORD_W-1:0]),
        .pop   (rng_ready),
        .dout  (rng_data),
        .full  (of_full),
        .empty (of_empty),
        .count (of_count)
    );

    // A full FIFO still takes the word when the consumer pops in the same cycle.
    assign drop = word_done && of_full && !rng_ready;

    logic [ERR_W-1:0] err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q    <= '0;
            drop_cnt <= '0;
        end else begin
            if (rd_issue && tq_full && !rd_data_valid) begin
                err_q[ERR_TAGQ_OVF_BIT] <= 1'b1;
            end
            if (rd_data_valid && tq_empty) begin
                err_q[ERR_ORPHAN_BIT] <= 1'b1;
            end
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    assign rng_valid     = !of_empty;
    assign rng_fifo_full = of_full;
    assign err_tagq_ovf  = err_q[ERR_TAGQ_OVF_BIT];
    assign err_orphan    = err_q[ERR_ORPHAN_BIT];

    logic unused_counts;
    assign unused_counts = ^{tq_count, of_count};

endmodule

// File: tb/tb_rlrd_rng_collector.sv
// Self-checking bench for rlrd_rng_collector: queue-based reference model plus directed literal checks.
module tb_rlrd_rng_collector;

    localparam int unsigned DATA_W = 512;
    localparam int unsigned IDX_W  = 9;
    localparam int unsigned N_IDX  = 8;
    localparam int unsigned TQ_D   = 16;
    localparam int unsigned OF_D   = 16;
`ifdef RLRD_RNG_VN_DEBIAS_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    rd_issue;
    logic                    rd_issue_is_rng;
    logic                    rd_data_valid;
    logic [DATA_W-1:0]       rd_data;
    logic [N_IDX*IDX_W-1:0]  cfg_idx;
    logic                    rng_valid;
    logic [31:0]             rng_data;
    logic                    rng_ready;
    logic                    rng_fifo_full;
    logic                    err_tagq_ovf;
    logic                    err_orphan;
    logic [15:0]             drop_cnt;

    rlrd_rng_collector #(
        .DATA_W     (DATA_W),
        .IDX_W      (IDX_W),
        .N_IDX      (N_IDX),
        .TAGQ_DEPTH (TQ_D),
        .OUT_DEPTH  (OF_D)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rd_issue        (rd_issue),
        .rd_issue_is_rng (rd_issue_is_rng),
        .rd_data_valid   (rd_data_valid),
        .rd_data         (rd_data),
        .cfg_idx         (cfg_idx),
        .rng_valid       (rng_valid),
        .rng_data        (rng_data),
        .rng_ready       (rng_ready),
        .rng_fifo_full   (rng_fifo_full),
        .err_tagq_ovf    (err_tagq_ovf),
        .err_orphan      (err_orphan),
        .drop_cnt        (drop_cnt)
    );

    initial forever #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    bit          chk_en = 0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: outstanding tags, pending bit stream, words in flight and the output FIFO.
    typedef struct {
        int unsigned due;
        logic [31:0] w;
    } pend_t;

    bit          m_tq[$];
    bit          m_bits[$];
    pend_t       m_pend[$];
    logic [31:0] m_of[$];
    bit          m_ovf;
    bit          m_orph;
    int unsigned m_drop;
    int unsigned cyc_n = 0;

    function automatic void consume_beat();
        bit          b[N_IDX];
        logic [31:0] w;
        for (int k = 0; k < N_IDX; k++) begin
            int unsigned idx;
            idx  = int'(cfg_idx[k*IDX_W +: IDX_W]) % DATA_W;
            b[k] = rd_data[idx];
        end
`ifdef RLRD_RNG_VN_DEBIAS_EN
        for (int j = 0; j < N_IDX/2; j++) begin
            logic [1:0] pr;
            pr = {b[2*j+1], b[2*j]};
            if (pr == 2'b01) m_bits.push_back(1'b0);
            else if (pr == 2'b10) m_bits.push_back(1'b1);
        end
`else
        for (int k = 0; k < N_IDX; k++) m_bits.push_back(b[k]);
`endif
        if (m_bits.size() >= 32) begin
            for (int i = 0; i < 32; i++) w[i] = m_bits[i];
            for (int i = 0; i < 32; i++) void'(m_bits.pop_front());
            m_pend.push_back('{due: cyc_n + LAT, w: w});
        end
    endfunction

    always @(posedge clk) begin
        cyc_n++;
        if (rst) begin
            m_tq.delete(); m_bits.delete(); m_pend.delete(); m_of.delete();
            m_ovf = 0; m_orph = 0; m_drop = 0;
        end else begin
            bit was_empty;
            bit was_full;
            if (m_of.size() > 0 && rng_ready) void'(m_of.pop_front());
            if (m_pend.size() > 0 && m_pend[0].due == cyc_n) begin
                if (m_of.size() < OF_D) m_of.push_back(m_pend[0].w);
                else if (m_drop < 16'hFFFF) m_drop++;
                void'(m_pend.pop_front());
            end
            was_empty = (m_tq.size() == 0);
            was_full  = (m_tq.size() == TQ_D);
            if (rd_data_valid) begin
                if (was_empty) m_orph = 1;
                else if (m_tq.pop_front()) consume_beat();
            end
            if (rd_issue) begin
                if (was_full && !rd_data_valid) m_ovf = 1;
                else m_tq.push_back(rd_issue_is_rng);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("rng_valid", 32'(rng_valid), 32'(m_of.size() > 0));
            if (m_of.size() > 0) check("rng_data", rng_data, m_of[0]);
            check("rng_fifo_full", 32'(rng_fifo_full), 32'(m_of.size() == OF_D));
            check("err_tagq_ovf", 32'(err_tagq_ovf), 32'(m_ovf));
            check("err_orphan", 32'(err_orphan), 32'(m_orph));
            check("drop_cnt", 32'(drop_cnt), m_drop);
        end
    end

    task automatic fill_data();
        for (int w = 0; w < DATA_W/32; w++) rd_data[w*32 +: 32] = $urandom;
    endtask

    task automatic drive(input bit iss, input bit rng, input bit dv, input logic [7:0] b);
        rd_issue        = iss;
        rd_issue_is_rng = rng;
        rd_data_valid   = dv;
        fill_data();
        rd_data[7:0]    = b;
        @(negedge clk);
        rd_issue        = 1'b0;
        rd_issue_is_rng = 1'b0;
        rd_data_valid   = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pop_one();
        rng_ready = 1'b1;
        tick();
        rng_ready = 1'b0;
    endtask

    task automatic cfg_linear();
        for (int k = 0; k < N_IDX; k++) cfg_idx[k*IDX_W +: IDX_W] = IDX_W'(k);
    endtask

    initial begin
        rst = 1'b1; rd_issue = 0; rd_issue_is_rng = 0; rd_data_valid = 0;
        rd_data = '0; rng_ready = 0;
        cfg_linear();
        tick();
        chk_en = 1;
        check("reset_valid", 32'(rng_valid), 32'd0);
        check("reset_data", rng_data, 32'd0);
        check("reset_full", 32'(rng_fifo_full), 32'd0);
        check("reset_drop", 32'(drop_cnt), 32'd0);
        check("reset_errs", 32'({err_tagq_ovf, err_orphan}), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Basic word assembly and latency
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 8'h00);
        drive(0, 0, 1, 8'hA5);
        drive(0, 0, 1, 8'h3C);
        drive(0, 0, 1, 8'hFF);
        drive(0, 0, 1, 8'h00);
`ifndef RLRD_RNG_VN_DEBIAS_EN
        check("lat_t1_valid", 32'(rng_valid), 32'd0);
        tick();
        check("lat_t2_valid", 32'(rng_valid), 32'd1);
        check("word1", rng_data, 32'h00FF3CA5);
        pop_one();
        check("word1_popped", 32'(rng_valid), 32'd0);
`else
        tick(); tick();
`endif

        // Non-RNG tag in the middle is skipped
        drive(1, 1, 0, 8'h00);
        drive(1, 0, 0, 8'h00);
        drive(1, 1, 0, 8'h00);
        drive(0, 0, 1, 8'h11);
        drive(0, 0, 1, 8'h22);
        drive(0, 0, 1, 8'h33);
        tick();
`ifndef RLRD_RNG_VN_DEBIAS_EN
        check("interleave_noword", 32'(rng_valid), 32'd0);
`endif
        drive(1, 1, 0, 8'h00);
        drive(1, 1, 0, 8'h00);
        drive(0, 0, 1, 8'h44);
        drive(0, 0, 1, 8'h55);
        tick();
`ifndef RLRD_RNG_VN_DEBIAS_EN
        check("interleave_word", rng_data, 32'h55443311);
        pop_one();
`else
        tick();
        pop_one();
`endif

        // Fill the output FIFO and overflow by one word
        for (int i = 0; i < 68; i++) begin
            drive(1, 1, 0, 8'h00);
            drive(0, 0, 1, 8'(i));
        end
        tick();
        tick();
`ifndef RLRD_RNG_VN_DEBIAS_EN
        check("fill_full", 32'(rng_fifo_full), 32'd1);
        check("fill_drop", 32'(drop_cnt), 32'd1);
        check("fill_head", rng_data, 32'h03020100);
`endif
        rng_ready = 1'b1;
        repeat (OF_D + 1) tick();
        rng_ready = 1'b0;
        check("drained", 32'(rng_valid), 32'd0);

        // Tag queue overflow, then orphan beat
        for (int i = 0; i < TQ_D; i++) drive(1, 0, 0, 8'h00);
        check("tagq_ovf_pre", 32'(err_tagq_ovf), 32'd0);
        drive(1, 0, 0, 8'h00);
        check("tagq_ovf", 32'(err_tagq_ovf), 32'd1);
        for (int i = 0; i < TQ_D; i++) drive(0, 0, 1, 8'h00);
        check("orphan_pre", 32'(err_orphan), 32'd0);
        drive(0, 0, 1, 8'hFF);
        check("orphan", 32'(err_orphan), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_clears_errs", 32'({err_tagq_ovf, err_orphan}), 32'd0);
        check("rst_clears_drop", 32'(drop_cnt), 32'd0);

`ifdef RLRD_RNG_VN_DEBIAS_EN
        // Each beat yields pairs 00,11,01,10 -> emits 0 then 1
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 0, 8'h00);
            drive(0, 0, 1, 8'h9C);
        end
        tick();
        check("vn_word", rng_data, 32'hAAAAAAAA);
        check("vn_valid", 32'(rng_valid), 32'd1);
        pop_one();
`endif

        // Reset with beats in flight
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 8'h00);
        drive(0, 0, 1, 8'hEE);
        drive(0, 0, 1, 8'hDD);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 8'h00);
        for (int i = 1; i <= 4; i++) drive(0, 0, 1, 8'(i));
        tick();
        tick();
`ifndef RLRD_RNG_VN_DEBIAS_EN
        check("rst_mid_word", rng_data, 32'h04030201);
        check("rst_mid_valid", 32'(rng_valid), 32'd1);
        pop_one();
        check("rst_mid_single", 32'(rng_valid), 32'd0);
`endif

        // Randomised traffic against the model
        for (int k = 0; k < N_IDX; k++) cfg_idx[k*IDX_W +: IDX_W] = IDX_W'($urandom);
        for (int i = 0; i < 3000; i++) begin
            int unsigned win;
            win = (i / 300) % 3;
            rd_issue        = ($urandom_range(99) < ((m_tq.size() < TQ_D) ? 45 : 10));
            rd_issue_is_rng = ($urandom_range(99) < 75);
            rd_data_valid   = ($urandom_range(99) < ((m_tq.size() > 0) ? 50 : 3));
            rng_ready       = (win == 0) ? 1'b0 : ($urandom_range(99) < ((win == 1) ? 30 : 90));
            rst             = (i == 1500);
            fill_data();
            tick();
        end
        rd_issue = 0; rd_data_valid = 0; rst = 0;
        while (m_tq.size() > 0) drive(0, 0, 1, 8'h5A);
        rng_ready = 1'b1;
        repeat (OF_D + 4) tick();
        rng_ready = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
